ctrl_pipeline: RTL

Registered successor to the combinational instruction controller. Decodes the ID-stage instruction into a control word and carries it through a parameterised chain of pipeline stages (default EX, MEM, WB). Also does load-use hazard detection, global stall, exception flush and exception reporting. It sits between the IF/ID register and the datapath, and gives every downstream stage its own valid-qualified control word.

---
 rtl/ctrl_pipeline_if.sv | 30 +++
 rtl/ctrl_pipeline.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline_if.sv
// ID-side handshake and per-stage control outputs of ctrl_pipeline.
// master = upstream/datapath side, slave = the pipeline controller.
interface ctrl_pipeline_if #(
  parameter int NUM_STAGES = 3
);
  localparam int CW_W = 24;

  logic [31:0]                 id_inst;
  logic                        id_valid;
  logic                        id_ready;
  logic                        stall_ext;
  logic                        flush;
  logic [NUM_STAGES*CW_W-1:0]  stage_cw;
  logic [NUM_STAGES*5-1:0]     stage_dst;
  logic [NUM_STAGES-1:0]       stage_valid;
  logic                        exc_valid;
  logic [4:0]                  exc_code;

  modport master (
    output id_inst, id_valid, stall_ext, flush,
    input  id_ready, stage_cw, stage_dst,
    input  stage_valid, exc_valid, exc_code
  );

  modport slave (
    input  id_inst, id_valid, stall_ext, flush,
    output id_ready, stage_cw, stage_dst,
    output stage_valid, exc_valid, exc_code
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// Registered instruction controller: decode in ID, then carry the control
// word through NUM_STAGES stages with load-use, stall, flush and exceptions.
module ctrl_pipeline #(
  parameter int NUM_STAGES = 3,
  parameter int EXC_STAGE  = 1
) (
  input  logic          clk,
  input  logic          resetn,
  ctrl_pipeline_if.slave bus
);
  localparam int CW_W = 24;

  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_AND  = 8'h03;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_XOR  = 8'h05;
  localparam logic [7:0] ALU_NOR  = 8'h06;
  localparam logic [7:0] ALU_SLT  = 8'h07;
  localparam logic [7:0] ALU_SLTU = 8'h08;
  localparam logic [7:0] ALU_SLL  = 8'h09;
  localparam logic [7:0] ALU_SRL  = 8'h0A;
  localparam logic [7:0] ALU_SRA  = 8'h0B;
  localparam logic [7:0] ALU_LUI  = 8'h0C;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign op    = bus.id_inst[31:26];
  assign rs    = bus.id_inst[25:21];
  assign rt    = bus.id_inst[20:16];
  assign rd    = bus.id_inst[15:11];
  assign funct = bus.id_inst[5:0];
  assign unused_shamt = ^bus.id_inst[10:6];

  logic       rw, mw, mr, rdst, asrc, m2r;
  logic       beq, jmp, shi, jv, lnk;
  logic       sysc, brk, ri, mf, mt;
  logic       r_alu, i_alu;
  logic [7:0] alu;

  always_comb begin
    {rw, mw, mr, rdst, asrc, m2r} = '0;
    {beq, jmp, shi, jv, lnk} = '0;
    {ri, mf, mt, r_alu, i_alu} = '0;
    alu = '0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h00: begin shi = 1'b1; r_alu = 1'b1; alu = ALU_SLL; end
          6'h02: begin shi = 1'b1; r_alu = 1'b1; alu = ALU_SRL; end
          6'h03: begin shi = 1'b1; r_alu = 1'b1; alu = ALU_SRA; end
          6'h04: begin r_alu = 1'b1; alu = ALU_SLL; end
          6'h06: begin r_alu = 1'b1; alu = ALU_SRL; end
          6'h07: begin r_alu = 1'b1; alu = ALU_SRA; end
          6'h08: jv = 1'b1;
          6'h09: begin jv = 1'b1; lnk = 1'b1; r_alu = 1'b1; end
          6'h0C, 6'h0D: begin end
          6'h20, 6'h21: begin r_alu = 1'b1; alu = ALU_ADD; end
          6'h22, 6'h23: begin r_alu = 1'b1; alu = ALU_SUB; end
          6'h24: begin r_alu = 1'b1; alu = ALU_AND; end
          6'h25: begin r_alu = 1'b1; alu = ALU_OR; end
          6'h26: begin r_alu = 1'b1; alu = ALU_XOR; end
          6'h27: begin r_alu = 1'b1; alu = ALU_NOR; end
          6'h2A: begin r_alu = 1'b1; alu = ALU_SLT; end
          6'h2B: begin r_alu = 1'b1; alu = ALU_SLTU; end
          default: ri = 1'b1;
        endcase
      end
      6'h02: jmp = 1'b1;
      6'h03: begin jmp = 1'b1; lnk = 1'b1; rw = 1'b1; end
      6'h04, 6'h05: begin beq = 1'b1; alu = ALU_SUB; end
      6'h08, 6'h09: begin i_alu = 1'b1; alu = ALU_ADD; end
      6'h0A: begin i_alu = 1'b1; alu = ALU_SLT; end
      6'h0B: begin i_alu = 1'b1; alu = ALU_SLTU; end
      6'h0C: begin i_alu = 1'b1; alu = ALU_AND; end
      6'h0D: begin i_alu = 1'b1; alu = ALU_OR; end
      6'h0E: begin i_alu = 1'b1; alu = ALU_XOR; end
      6'h0F: begin i_alu = 1'b1; alu = ALU_LUI; end
      6'h10: begin
        if (rs == 5'd0) begin
          mf = 1'b1;
          rw = 1'b1;
        end else if (rs == 5'd4) begin
          mt = 1'b1;
        end else begin
          ri = 1'b1;
        end
      end
      6'h23: begin rw = 1'b1; mr = 1'b1; asrc = 1'b1; m2r = 1'b1; alu = ALU_ADD; end
      6'h2B: begin mw = 1'b1; asrc = 1'b1; alu = ALU_ADD; end
      default: ri = 1'b1;
    endcase
    rw   = rw | r_alu | i_alu;
    rdst = r_alu;
    asrc = asrc | i_alu;
  end

  // BREAK matches on funct alone, exactly as the old controller did
  assign sysc = (op == 6'h00) && (funct == 6'h0C);
  assign brk  = (funct == 6'h0D);

  logic [CW_W-1:0] dec_cw;
  logic [4:0]      dec_dst;

  assign dec_cw = {mt, mf, ri, brk, sysc, lnk, jv, shi,
                   jmp, beq, m2r, asrc, rdst, mr, mw, rw, alu};
  assign dec_dst = (lnk && !rdst) ? 5'd31 : (rdst ? rd : rt);

  logic [NUM_STAGES-1:0] v_q;
  logic [CW_W-1:0]       cw_q  [NUM_STAGES];
  logic [4:0]            dst_q [NUM_STAGES];
  logic                  hazard, load;

  assign hazard = bus.id_valid && v_q[0] && cw_q[0][10] &&
                  (dst_q[0] != 5'd0) &&
                  ((dst_q[0] == rs) || (dst_q[0] == rt));
  assign bus.id_ready = !bus.stall_ext && !hazard && !bus.flush;
  assign load = bus.id_valid && !hazard;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        cw_q[k]  <= '0;
        dst_q[k] <= '0;
      end
    end else if (bus.flush) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        v_q[k]   <= 1'b0;
        cw_q[k]  <= '0;
        dst_q[k] <= '0;
      end
      if (!bus.stall_ext) begin
        v_q[NUM_STAGES-1]   <= v_q[NUM_STAGES-2];
        cw_q[NUM_STAGES-1]  <= cw_q[NUM_STAGES-2];
        dst_q[NUM_STAGES-1] <= dst_q[NUM_STAGES-2];
      end
    end else if (!bus.stall_ext) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        cw_q[k]  <= cw_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
      v_q[0]   <= load;
      cw_q[0]  <= load ? dec_cw : '0;
      dst_q[0] <= load ? dec_dst : '0;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign bus.stage_cw[k*CW_W +: CW_W] = cw_q[k];
    assign bus.stage_dst[k*5 +: 5]      = dst_q[k];
  end
  assign bus.stage_valid = v_q;

  logic [2:0] xf;
  assign xf = {3{v_q[EXC_STAGE]}} & cw_q[EXC_STAGE][21:19];
  assign bus.exc_valid = |xf;

  always_comb begin
    bus.exc_code = 5'h00;
    priority case (1'b1)
      xf[2]:   bus.exc_code = 5'h0A;
      xf[0]:   bus.exc_code = 5'h08;
      xf[1]:   bus.exc_code = 5'h09;
      default: bus.exc_code = 5'h00;
    endcase
  end
endmodule
